// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the multi-port register file.
// Read indices and read data are packed per port, lowest port in the lowest slice.
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2
);
  logic                        ready;
  logic                        wen;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]       wdata;
  logic                        ren;
  logic [NREAD*ADDR_WIDTH-1:0] raddr;
  logic [NREAD*DATA_WIDTH-1:0] rdata;
  logic [NREAD-1:0]            rbusy;
  logic                        alloc_en;
  logic [ADDR_WIDTH-1:0]       alloc_addr;

  modport master (
    input  ready, rdata, rbusy,
    output wen, waddr, wdata, ren, raddr, alloc_en, alloc_addr
  );

  modport slave (
    output ready, rdata, rbusy,
    input  wen, waddr, wdata, ren, raddr, alloc_en, alloc_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardwired zero register, optional write bypass,
// a post-reset clear sequencer and a per-register busy scoreboard for in-flight writes.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit BYP_EN = BYPASS[0];
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic                  w_active;
  logic                  w_clr_en;
  logic                  w_wr_en;
  logic                  w_al_en;

  // State register: any reset edge restarts the clear sequence from index 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + IDX_ONE;
      end else begin
        r_clr_idx <= r_clr_idx;
      end
    end
  end

  // Next state: leave CLEAR on the edge that zeroes the last entry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_idx == IDX_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: writebacks and allocs only take effect once the file is ready
  always_comb begin
    w_active = 1'b0;
    w_clr_en = 1'b0;
    case (r_state)
      ST_CLEAR: w_clr_en = rst_n;
      ST_READY: w_active = 1'b1;
      default: begin
        w_active = 1'b0;
        w_clr_en = 1'b0;
      end
    endcase
    w_wr_en = w_active && rst_n && bus.wen && (bus.waddr != '0);
    w_al_en = w_active && bus.alloc_en && (bus.alloc_addr != '0);
  end

  assign bus.ready = w_active;

  // Storage has no reset of its own; the sequencer zeroes it one entry per edge
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_rf[r_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_rf[bus.waddr] <= bus.wdata;
    end else begin
      r_rf[r_clr_idx] <= r_rf[r_clr_idx];
    end
  end

  // Busy update: a write retires the producer, a same-cycle alloc re-arms it
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < DEPTH; k++) begin
      w_busy_nxt[k] = (r_busy[k] && !(w_wr_en && (bus.waddr == ADDR_WIDTH'(k))))
                   || (w_al_en && (bus.alloc_addr == ADDR_WIDTH'(k)));
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register, held at zero until the file is ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_active) begin
      r_busy <= w_busy_nxt;
    end else begin
      r_busy <= '0;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rb;

    assign w_ra = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    // Read port: zero register and disabled reads return 0, else bypass or array
    always_comb begin
      w_rd = '0;
      w_rb = 1'b0;
      if (!w_active || !bus.ren || (w_ra == '0)) begin
        w_rd = '0;
      end else if (BYP_EN && bus.wen && (bus.waddr == w_ra)) begin
        w_rd = bus.wdata;
      end else begin
        w_rd = r_rf[w_ra];
      end
      if (w_active) begin
        w_rb = r_busy[w_ra];
      end else begin
        w_rb = 1'b0;
      end
    end

    assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign bus.rbusy[gi] = w_rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a 4-port bypassing file and a 2-port non-bypassing file share one
// stimulus stream; expectations come from an array model of the register file rules.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  logic wen;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic ren;
  logic [4:0] ra [4];
  logic alloc_en;
  logic [4:0] alloc_addr;

  regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(4)) if_a ();
  regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2)) if_b ();

  assign if_a.wen = wen;          assign if_b.wen = wen;
  assign if_a.waddr = waddr;      assign if_b.waddr = waddr;
  assign if_a.wdata = wdata;      assign if_b.wdata = wdata;
  assign if_a.ren = ren;          assign if_b.ren = ren;
  assign if_a.alloc_en = alloc_en;     assign if_b.alloc_en = alloc_en;
  assign if_a.alloc_addr = alloc_addr; assign if_b.alloc_addr = alloc_addr;
  assign if_a.raddr = {ra[3], ra[2], ra[1], ra[0]};
  assign if_b.raddr = {ra[1], ra[0]};

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(4), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference model: storage, busy flags, readiness and clear progress
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_ready;
  int          m_cnt;

  typedef struct {
    logic         rdy;
    logic [127:0] rd_a;
    logic [3:0]   rb_a;
    logic [63:0]  rd_b;
    logic [1:0]   rb_b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!m_ready || !ren || a == 5'd0) return 32'd0;
    if (byp && wen && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0;
      m_ready = 1'b0;
      foreach (m_busy[k]) m_busy[k] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1'b1;
        foreach (m_mem[k]) m_mem[k] = 32'd0;
      end
    end else begin
      if (wen && waddr != 5'd0) begin
        m_mem[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic step(input bit do_chk);
    exp_t e;
    if (do_chk) begin
      e.rdy = m_ready;
      for (int i = 0; i < 4; i++) begin
        e.rd_a[i*32 +: 32] = exp_rd(ra[i], 1'b1);
        e.rb_a[i] = m_ready ? m_busy[ra[i]] : 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        e.rd_b[i*32 +: 32] = exp_rd(ra[i], 1'b0);
        e.rb_b[i] = m_ready ? m_busy[ra[i]] : 1'b0;
      end
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = 5'd0; wdata = 32'd0;
    alloc_en = 1'b0; alloc_addr = 5'd0; ren = 1'b1;
  endtask

  task automatic rd_all(input logic [4:0] a);
    for (int i = 0; i < 4; i++) ra[i] = a;
  endtask

  // Monitor: compare every presented read cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready_a", {127'd0, if_a.ready}, {127'd0, e.rdy});
      chk("ready_b", {127'd0, if_b.ready}, {127'd0, e.rdy});
      chk("rdata_a", if_a.rdata, e.rd_a);
      chk("rbusy_a", {124'd0, if_a.rbusy}, {124'd0, e.rb_a});
      chk("rdata_b", {64'd0, if_b.rdata}, {64'd0, e.rd_b});
      chk("rbusy_b", {126'd0, if_b.rbusy}, {126'd0, e.rb_b});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    m_ready = 1'b0; m_cnt = 0;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    foreach (m_mem[k]) m_mem[k] = 32'd0;
    idle(); rd_all(5'd0);
    rst_n = 1'b0;
    step(1'b0);
    step(1'b1); step(1'b1);

    // Clear sequence with writes/allocs that must be ignored
    rst_n = 1'b1;
    for (int c = 0; c < 33; c++) begin
      wen = 1'b1; waddr = 5'd9; wdata = $urandom;
      alloc_en = 1'b1; alloc_addr = 5'd9;
      for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 31));
      ra[0] = 5'd9;
      step(1'b1);
    end
    idle();
    for (int b = 0; b < 32; b += 4) begin
      for (int i = 0; i < 4; i++) ra[i] = 5'(b + i);
      step(1'b1);
    end

    // Basic write/read and zero register
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rd_all(5'd0); step(1'b1);
    idle(); rd_all(5'd5); step(1'b1);
    wen = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; rd_all(5'd0); step(1'b1);
    idle(); step(1'b1);

    // Bypass and read-enable gating
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; rd_all(5'd7); step(1'b1);
    wen = 1'b1; waddr = 5'd7; wdata = 32'h5A5A5A5A; ren = 1'b0; step(1'b1);
    idle(); step(1'b1);

    // Scoreboard: alloc, retire, simultaneous alloc+write, alloc of x0
    alloc_en = 1'b1; alloc_addr = 5'd3; ra[0] = 5'd3; ra[1] = 5'd3; ra[2] = 5'd0; ra[3] = 5'd4;
    step(1'b1);
    idle(); step(1'b1);
    alloc_en = 1'b1; alloc_addr = 5'd3; step(1'b1);
    idle(); wen = 1'b1; waddr = 5'd3; wdata = 32'h0BAD_F00D; step(1'b1);
    idle(); step(1'b1);
    wen = 1'b1; waddr = 5'd3; wdata = 32'h1357_9BDF; alloc_en = 1'b1; alloc_addr = 5'd3; step(1'b1);
    idle(); step(1'b1);
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_all(5'd0); step(1'b1);
    idle(); step(1'b1);

    // Reset mid-clear, then restart; x9 traffic during clear must leave no trace
    rst_n = 1'b0; step(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step(1'b1);
    rst_n = 1'b0; step(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 33; c++) begin
      wen = 1'b1; waddr = 5'd9; wdata = $urandom; alloc_en = 1'b1; alloc_addr = 5'd9;
      rd_all(5'd9);
      step(1'b1);
    end
    idle(); ra[0] = 5'd9; ra[1] = 5'd3; ra[2] = 5'd5; ra[3] = 5'd7; step(1'b1);

    // Randomized traffic with collisions on a small index window
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      wen = $urandom_range(0, 1) == 1;
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      ren = $urandom_range(0, 7) != 0;
      alloc_en = $urandom_range(0, 2) == 0;
      alloc_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 9));
      step(1'b1);
    end
    rst_n = 1'b1; idle();

    @(negedge clk); #1;
    chk("drain", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
